// File: rtl/spi_pkg.sv
// Shared state encoding and sizing helpers for custom_spi_master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        HIGH      = 3'd2,
        LOW       = 3'd3,
        WAIT_NEXT = 3'd4,
        TRAIL     = 3'd5,
        GAP       = 3'd6
    } spi_state_e;

    localparam int SPI_DATA_W = 8;

    function automatic int div_cnt_w(input int clk_div);
        return (clk_div <= 1) ? 1 : $clog2(clk_div);
    endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Down-counter that times one SCK half period (CLK_DIV clk cycles) per start pulse.
module spi_half_period_timer
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int              CW   = div_cnt_w(CLK_DIV);
    localparam logic [CW-1:0]   LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_active;

    // Reload on start, then count down; done fires on the zero cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= {CW{1'b0}};
            r_active <= 1'b0;
        end else if (start) begin
            r_cnt    <= LOAD;
            r_active <= 1'b1;
        end else if (r_active && (r_cnt == {CW{1'b0}})) begin
            r_active <= 1'b0;
        end else if (r_active) begin
            r_cnt    <= r_cnt - CW'(1);
        end else begin
            r_cnt    <= r_cnt;
        end
    end

    assign done = r_active && (r_cnt == {CW{1'b0}});

endmodule

// File: rtl/custom_spi_master.sv
// Mode-0 MSB-first SPI master with valid/ready TX and strobed RX.
// Optional SPI_LOOPBACK_EN adds a loopback input that feeds MOSI back to the sampler.
module custom_spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              spi_sck_o,
    output logic              spi_ss_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i
`ifdef SPI_LOOPBACK_EN
    ,
    input  logic              loopback
`endif
);

    localparam int BW = $clog2(DATA_W);

    spi_state_e        r_state, w_state_next;
    logic [DATA_W-1:0] r_shift, w_shift_next, w_shift_in;
    logic [BW-1:0]     r_bit_cnt, w_bit_cnt_next;
    logic              r_last, w_last_next;
    logic              r_sck, w_sck_next, r_ss, w_ss_next, r_mosi, w_mosi_next;
    logic              r_busy, w_busy_next, r_rx_valid, w_rx_valid_next;
    logic [DATA_W-1:0] r_rx_data, w_rx_data_next;
    logic              w_hs, w_miso, w_start, w_tdone, w_bits_left;

    assign tx_ready    = !rst && ((r_state == IDLE) || (r_state == WAIT_NEXT));
    assign w_hs        = tx_valid && tx_ready;
    assign w_bits_left = (r_bit_cnt != {BW{1'b0}});
`ifdef SPI_LOOPBACK_EN
    assign w_miso      = loopback ? r_mosi : spi_miso_i;
`else
    assign w_miso      = spi_miso_i;
`endif
    assign w_shift_in  = {r_shift[DATA_W-2:0], w_miso};
    // Every entry into a timed state restarts the half-period timer
    assign w_start     = (w_state_next != r_state) && (w_state_next != IDLE) &&
                         (w_state_next != WAIT_NEXT);

    spi_half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .done  (w_tdone)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, WAIT_NEXT: if (w_hs) w_state_next = SETUP; else w_state_next = r_state;
            SETUP, LOW:      if (w_tdone) w_state_next = HIGH; else w_state_next = r_state;
            HIGH: begin
                if (!w_tdone)        w_state_next = HIGH;
                else if (w_bits_left) w_state_next = LOW;
                else if (r_last)     w_state_next = TRAIL;
                else                 w_state_next = WAIT_NEXT;
            end
            TRAIL:   if (w_tdone) w_state_next = GAP;  else w_state_next = TRAIL;
            GAP:     if (w_tdone) w_state_next = IDLE; else w_state_next = GAP;
            default: w_state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs and shift datapath
    always_comb begin
        w_sck_next      = r_sck;
        w_ss_next       = r_ss;
        w_mosi_next     = r_mosi;
        w_busy_next     = r_busy;
        w_rx_valid_next = 1'b0;
        w_rx_data_next  = r_rx_data;
        w_shift_next    = r_shift;
        w_bit_cnt_next  = r_bit_cnt;
        w_last_next     = r_last;
        case (r_state)
            IDLE, WAIT_NEXT: begin
                if (w_hs) begin
                    w_shift_next   = tx_data;
                    w_bit_cnt_next = BW'(DATA_W - 1);
                    w_last_next    = tx_last;
                    w_ss_next      = 1'b0;
                    w_sck_next     = 1'b0;
                    w_mosi_next    = tx_data[DATA_W-1];
                    w_busy_next    = 1'b1;
                end else begin
                    w_sck_next     = 1'b0;
                end
            end
            SETUP, LOW: if (w_tdone) w_sck_next = 1'b1; else w_sck_next = r_sck;
            HIGH: begin
                if (w_tdone) begin
                    w_sck_next   = 1'b0;
                    w_shift_next = w_shift_in;
                    if (w_bits_left) begin
                        w_mosi_next    = r_shift[DATA_W-2];
                        w_bit_cnt_next = r_bit_cnt - BW'(1);
                    end else begin
                        w_rx_valid_next = 1'b1;
                        w_rx_data_next  = w_shift_in;
                    end
                end else begin
                    w_sck_next = r_sck;
                end
            end
            TRAIL:   if (w_tdone) w_ss_next = 1'b1;   else w_ss_next = r_ss;
            GAP:     if (w_tdone) w_busy_next = 1'b0; else w_busy_next = r_busy;
            default: w_sck_next = 1'b0;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sck      <= 1'b0;
            r_ss       <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= {DATA_W{1'b0}};
            r_shift    <= {DATA_W{1'b0}};
            r_bit_cnt  <= {BW{1'b0}};
            r_last     <= 1'b0;
        end else begin
            r_sck      <= w_sck_next;
            r_ss       <= w_ss_next;
            r_mosi     <= w_mosi_next;
            r_busy     <= w_busy_next;
            r_rx_valid <= w_rx_valid_next;
            r_rx_data  <= w_rx_data_next;
            r_shift    <= w_shift_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_last     <= w_last_next;
        end
    end

    assign spi_sck_o  = r_sck;
    assign spi_ss_o   = r_ss;
    assign spi_mosi_o = r_mosi;
    assign busy       = r_busy;
    assign rx_valid   = r_rx_valid;
    assign rx_data    = r_rx_data;

endmodule

// File: tb/tb_custom_spi_master.sv
// Scoreboarded bench for custom_spi_master: CLK_DIV=4 and CLK_DIV=1 instances share one slave model.
module tb_custom_spi_master;

    logic       clk = 1'b0;
    logic       rst, tx_valid, tx_last, sel, force0;
    logic [7:0] tx_data;
`ifdef SPI_LOOPBACK_EN
    logic       lb;
`endif

    logic       sck4, ss4, mosi4, rxv4, rdy4, busy4;
    logic       sck1, ss1, mosi1, rxv1, rdy1, busy1;
    logic [7:0] rxd4, rxd1;
    logic       tv4, tv1, miso;
    logic       sck_m, ss_m, mosi_m, rxv_m, rdy_m, busy_m;
    logic [7:0] rxd_m;

    int checks = 0, errors = 0, cyc = 0;
    int hs_cyc = 0, ss_rise_cyc = 0, ss_rise_cnt = 0, rx_cnt = 0, done_cyc = 0;
    int scnt = 0, capcnt = 0, mdiv = 4;
    logic [7:0] cur = 8'h00, cap = 8'h00, etx, erx;
    logic need = 1'b1, prev_sck = 1'b0, prev_ss = 1'b1;
    logic [7:0] exp_tx_q[$], exp_rx_q[$], resp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign tv4    = tx_valid & ~sel;
    assign tv1    = tx_valid & sel;
    assign miso   = force0 ? 1'b0 : cur[7];
    assign sck_m  = sel ? sck1 : sck4;
    assign ss_m   = sel ? ss1 : ss4;
    assign mosi_m = sel ? mosi1 : mosi4;
    assign rxv_m  = sel ? rxv1 : rxv4;
    assign rdy_m  = sel ? rdy1 : rdy4;
    assign busy_m = sel ? busy1 : busy4;
    assign rxd_m  = sel ? rxd1 : rxd4;

    custom_spi_master #(.CLK_DIV(4), .DATA_W(8)) dut4 (
        .clk(clk), .rst(rst), .tx_valid(tv4), .tx_ready(rdy4), .tx_data(tx_data),
        .tx_last(tx_last), .rx_valid(rxv4), .rx_data(rxd4), .busy(busy4),
        .spi_sck_o(sck4), .spi_ss_o(ss4), .spi_mosi_o(mosi4), .spi_miso_i(miso)
`ifdef SPI_LOOPBACK_EN
        , .loopback(lb)
`endif
    );

    custom_spi_master #(.CLK_DIV(1), .DATA_W(8)) dut1 (
        .clk(clk), .rst(rst), .tx_valid(tv1), .tx_ready(rdy1), .tx_data(tx_data),
        .tx_last(tx_last), .rx_valid(rxv1), .rx_data(rxd1), .busy(busy1),
        .spi_sck_o(sck1), .spi_ss_o(ss1), .spi_mosi_o(mosi1), .spi_miso_i(miso)
`ifdef SPI_LOOPBACK_EN
        , .loopback(lb)
`endif
    );

    // Slave model and scoreboard: shifts MISO on SCK falls, captures MOSI on rises, checks RX strobes
    always @(negedge clk) begin
        if (rst) begin
            scnt = 0; capcnt = 0; need = 1'b1; cur = 8'h00; prev_sck = 1'b0; prev_ss = 1'b1;
        end else begin
            mdiv = sel ? 1 : 4;
            if (prev_sck && !sck_m) begin
                cur = cur << 1;
                scnt++;
                if (scnt == 8) begin scnt = 0; need = 1'b1; end
            end
            if (!prev_sck && sck_m) begin
                checks++;
                if (cyc - hs_cyc != 1 + (2 * capcnt + 1) * mdiv) begin
                    errors++;
                    $display("FAIL sck_rise_time bit %0d: got cycle %0d, expected %0d",
                             capcnt, cyc - hs_cyc, 1 + (2 * capcnt + 1) * mdiv);
                end
                cap = {cap[6:0], mosi_m};
                capcnt++;
                if (capcnt == 8) begin
                    capcnt = 0;
                    checks++;
                    if (exp_tx_q.size() == 0) begin
                        errors++;
                        $display("FAIL mosi_unexpected: got byte %h, expected no transfer", cap);
                    end else begin
                        etx = exp_tx_q.pop_front();
                        if (cap !== etx) begin
                            errors++;
                            $display("FAIL mosi_byte: got %h, expected %h", cap, etx);
                        end
                    end
                end
            end
            if (rxv_m) begin
                rx_cnt++;
                checks++;
                if (exp_rx_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected: got rx_data %h, expected no strobe", rxd_m);
                end else begin
                    erx = exp_rx_q.pop_front();
                    if (rxd_m !== erx) begin
                        errors++;
                        $display("FAIL rx_data: got %h, expected %h", rxd_m, erx);
                    end
                end
                checks++;
                if (cyc - hs_cyc != 1 + 16 * mdiv) begin
                    errors++;
                    $display("FAIL rx_time: got cycle %0d, expected %0d", cyc - hs_cyc, 1 + 16 * mdiv);
                end
            end
            if (!prev_ss && ss_m) begin ss_rise_cnt++; ss_rise_cyc = cyc; end
            if (rdy_m && !ss_m) begin
                checks++;
                if (sck_m !== 1'b0) begin
                    errors++;
                    $display("FAIL wait_next_sck: got %b, expected 0", sck_m);
                end
            end
            if (need && resp_q.size() > 0) begin cur = resp_q.pop_front(); need = 1'b0; end
            prev_sck = sck_m;
            prev_ss  = ss_m;
        end
    end

    task automatic send(input logic [7:0] d, input logic l, input logic [7:0] resp, input logic [7:0] er);
        int n, hc;
        n = 0;
        @(negedge clk);
        tx_valid = 1'b1; tx_data = d; tx_last = l;
        while (!rdy_m && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (!rdy_m) begin
            errors++;
            $display("FAIL send_handshake: tx_ready got %b, expected 1", rdy_m);
        end else begin
            hc = cyc;
            #1;
            exp_tx_q.push_back(d); resp_q.push_back(resp); exp_rx_q.push_back(er);
            hs_cyc = hc;
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(rdy_m && !busy_m && ss_m) && n < 2000) begin @(negedge clk); n++; end
        done_cyc = cyc;
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL wait_idle: busy got %b, expected 0 within 2000 cycles", busy_m);
        end
        checks++;
        if (exp_tx_q.size() != 0 || exp_rx_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: got tx %0d rx %0d pending, expected 0 0",
                     exp_tx_q.size(), exp_rx_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({ss4, sck4, mosi4, rxv4, busy4, rdy4, ss1, rdy1} !== 8'b1000_0010 || rxd4 !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got ss/sck/mosi/rxv/busy/rdy/ss1/rdy1=%b rxd=%h, expected 10000010 00",
                     {ss4, sck4, mosi4, rxv4, busy4, rdy4, ss1, rdy1}, rxd4);
        end
        @(negedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy4 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", rdy4); end
    endtask

    task automatic test_single();
        send(8'hA5, 1'b1, 8'h3C, 8'h3C);
        wait_idle();
        checks++;
        if (ss_rise_cyc - hs_cyc != 69) begin
            errors++; $display("FAIL ss_release_time: got %0d, expected 69", ss_rise_cyc - hs_cyc);
        end
        checks++;
        if (done_cyc - hs_cyc != 73) begin
            errors++; $display("FAIL ready_time: got %0d, expected 73", done_cyc - hs_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int r_ss, r_rx;
        r_ss = ss_rise_cnt; r_rx = rx_cnt;
        send(8'h01, 1'b0, 8'h81, 8'h81);
        send(8'h80, 1'b0, 8'h7E, 8'h7E);
        send(8'hFF, 1'b1, 8'h00, 8'h00);
        wait_idle();
        checks++;
        if (ss_rise_cnt != r_ss + 1) begin
            errors++; $display("FAIL burst_ss_rises: got %0d, expected 1", ss_rise_cnt - r_ss);
        end
        checks++;
        if (rx_cnt != r_rx + 3) begin
            errors++; $display("FAIL burst_rx_count: got %0d, expected 3", rx_cnt - r_rx);
        end
    endtask

    task automatic test_hold_valid();
        int n, acc, hc, r_rx;
        n = 0; acc = 0; r_rx = rx_cnt;
        @(negedge clk);
        tx_valid = 1'b1; tx_last = 1'b1;
        while (acc < 2 && n < 600) begin
            tx_data = 8'($urandom_range(0, 255));
            if (rdy_m) begin
                hc = cyc;
                #1;
                exp_tx_q.push_back(tx_data); resp_q.push_back(~tx_data); exp_rx_q.push_back(~tx_data);
                hs_cyc = hc;
                acc++;
            end
            @(negedge clk);
            n++;
        end
        tx_valid = 1'b0;
        checks++;
        if (acc != 2) begin errors++; $display("FAIL hold_handshakes: got %0d, expected 2", acc); end
        wait_idle();
        checks++;
        if (rx_cnt != r_rx + 2) begin
            errors++; $display("FAIL hold_rx_count: got %0d, expected 2", rx_cnt - r_rx);
        end
    endtask

    task automatic test_midreset();
        int r_rx;
        send(8'hF0, 1'b1, 8'h24, 8'h24);
        while (cyc - hs_cyc < 30) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({ss4, sck4, mosi4, busy4, rdy4, rxv4} !== 6'b100000) begin
            errors++;
            $display("FAIL async_reset: got ss/sck/mosi/busy/rdy/rxv=%b, expected 100000",
                     {ss4, sck4, mosi4, busy4, rdy4, rxv4});
        end
        exp_tx_q.delete(); exp_rx_q.delete(); resp_q.delete();
        r_rx = rx_cnt;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy4 !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b, expected 1", rdy4); end
        checks++;
        if (rx_cnt != r_rx) begin errors++; $display("FAIL midreset_no_rx: got %0d, expected 0", rx_cnt - r_rx); end
        send(8'h5A, 1'b1, 8'hC6, 8'hC6);
        wait_idle();
        checks++;
        if (rx_cnt != r_rx + 1) begin
            errors++; $display("FAIL midreset_fresh: got %0d strobes, expected 1", rx_cnt - r_rx);
        end
    endtask

    task automatic test_div1();
        sel = 1'b1;
        send(8'hC3, 1'b1, 8'h5E, 8'h5E);
        wait_idle();
        checks++;
        if (done_cyc - hs_cyc != 19) begin
            errors++; $display("FAIL div1_ready_time: got %0d, expected 19", done_cyc - hs_cyc);
        end
        sel = 1'b0;
    endtask

`ifdef SPI_LOOPBACK_EN
    task automatic test_loopback();
        lb = 1'b1; force0 = 1'b1;
        send(8'h96, 1'b0, 8'h00, 8'h96);
        send(8'h69, 1'b1, 8'h00, 8'h69);
        wait_idle();
        lb = 1'b0; force0 = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00; sel = 1'b0; force0 = 1'b0;
`ifdef SPI_LOOPBACK_EN
        lb = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_valid();
        test_midreset();
        test_div1();
`ifdef SPI_LOOPBACK_EN
        test_loopback();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/custom_spi_master.md
Name: custom_spi_master

Overview:
Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first. It drives the custom-master side (interface B) of the board SPI pin mux: SCK, SS, MOSI out and MISO in. A valid/ready TX stream feeds it and a single-cycle RX strobe returns each received byte. The tx_last flag groups multiple bytes under one SS assertion.

Parameters:
CLK_DIV, 4, SCK half-period in clk cycles; legal range >= 1.
DATA_W, 8, bits per transfer.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
tx_valid  in  1  TX byte offered
tx_ready  out  1  master accepts the byte; a transfer occurs when tx_valid && tx_ready on a clk edge
tx_data  in  DATA_W  byte to shift out; captured at the handshake
tx_last  in  1  deassert SS after this byte; captured at the handshake
rx_valid  out  1  one-cycle strobe, rx_data valid
rx_data  out  DATA_W  byte received during the just-finished transfer
busy  out  1  high from handshake until SS is released and the gap has elapsed
spi_sck_o  out  1  to mux custom_spi_sck_o
spi_ss_o  out  1  to mux custom_spi_ss_o, active low
spi_mosi_o  out  1  to mux custom_spi_mosi_o
spi_miso_i  in  1  from mux custom_spi_miso_i

Behaviour:
- Reset (async, immediate, including mid-transfer):
  - sck=0, ss=1, mosi=0, rx_valid=0, rx_data=0, busy=0, tx_ready=0.
  - Divider, bit counter and state are cleared.
  - State goes to IDLE, where tx_ready=1 on the first cycle after reset release.
- All outputs are registered except tx_ready. tx_ready is decoded from state: 1 in IDLE and WAIT_NEXT, 0 otherwise.
- States:
  - IDLE: ss=1, sck=0. On handshake (cycle 0), load the shift register and the last flag. Go to SETUP. At cycle 1: ss=0, mosi=tx_data[7], busy=1.
  - SETUP: lasts CLK_DIV cycles. Then go to HIGH with sck=1 (first rise at cycle 1+CLK_DIV).
  - HIGH: lasts CLK_DIV cycles.
    - At exit, sample spi_miso_i into the shift LSB.
    - Set sck=0.
    - If bits remain: mosi = next bit, go to LOW.
    - Otherwise, the final fall: rx_valid=1 for one cycle and rx_data=shifted byte.
      - If last: go to TRAIL.
      - Else: go to WAIT_NEXT.
  - LOW: lasts CLK_DIV cycles, then go to HIGH with sck=1.
  - WAIT_NEXT: ss stays 0, sck=0, tx_ready=1, no timeout. On handshake: mosi=bit7 next cycle, go to SETUP.
  - TRAIL: lasts CLK_DIV cycles with ss=0. Then ss=1, go to GAP.
  - GAP: lasts CLK_DIV cycles with ss=1. Then busy=0, go to IDLE.
- Timing with CLK_DIV=4, single last byte:
  - Handshake at cycle 0.
  - Rises at 5, 13, …, 61; falls at 9, 17, …, 65.
  - rx_valid at 65; ss=1 at 69; tx_ready=1 at 73.
- Generic formula: bit k (k=0 is the MSB) rises at 1+(2k+1)·CLK_DIV and falls at 1+(2k+2)·CLK_DIV.
- mosi changes only on falling edges or at SS assertion. It holds its value across the rising edge.
- tx_valid is ignored while tx_ready=0. Changes to tx_data after the handshake have no effect.
- rx_valid has no backpressure. The consumer must take it in the cycle it is asserted.
- CLK_DIV=1: SCK period is 2 clk cycles, and the same state sequence applies.

Optional Feature:
SPI_LOOPBACK_EN:
- Defined: adds input port `loopback` (1 bit). When loopback=1, the receive sampler uses spi_mosi_o instead of spi_miso_i. In that mode rx_data equals tx_data for every byte.
- Undefined: the port is absent and the sampler always uses spi_miso_i.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, SETUP, HIGH, LOW, WAIT_NEXT, TRAIL, GAP);
  - SPI_DATA_W=8;
  - the divider counter width function (clog2 of CLK_DIV).
- One sub-module, spi_half_period_timer. It is a down-counter loaded with CLK_DIV-1 on `start` and emits a `done` strobe on its final cycle. It is reused by the SETUP, HIGH, LOW, TRAIL and GAP states.

Test Plan:
1. Reset, then CLK_DIV=4: send 0xA5 last=1 with MISO driven by a slave model returning 0x3C. Expect:
   - mosi sequence 1,0,1,0,0,1,0,1 sampled at rises 5…61;
   - rx_valid at cycle 65 with rx_data=0x3C;
   - ss high at 69 and tx_ready at 73.
2. Three-byte burst 0x01, 0x80, 0xFF, last on the third. Expect:
   - ss stays low across all bytes with no glitch;
   - three rx_valid pulses;
   - sck idles low in WAIT_NEXT;
   - ss rises only after the third byte.
3. Hold tx_valid high with changing tx_data while busy. Expect only the handshaken bytes to be transmitted and no extra transfers.
4. Assert rst at cycle 30 of a transfer. Expect:
   - ss=1, sck=0, mosi=0 immediately (asynchronously);
   - no rx_valid;
   - a fresh 0x5A transfer after reset completes correctly.
5. CLK_DIV=1, byte 0xC3. Expect SCK period of 2 cycles, rx_valid at cycle 17, and correct data.
6. With SPI_LOOPBACK_EN and loopback=1, send 0x96 and 0x69. Expect rx_data=0x96 and 0x69 with spi_miso_i tied to 0.
